wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width of all Wishbone ports.
REQ-002 SHALL have parameter TIMEOUT, default 255, maximum cycles a granted strobe may wait for ACK.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 instr_bus  wishbone.SLAVE  XLEN bundle  port 0, instruction fetch requester.
REQ-007 data_bus  wishbone.SLAVE  XLEN bundle  port 1, load/store requester.
REQ-008 mem_bus  wishbone.MASTER  XLEN bundle  shared memory port.
REQ-009 owner  output  2  current grant encoding: NONE, INSTR or DATA.
REQ-010 bus_err  output  1  sticky flag; set on ACK timeout.

Function
REQ-011 SHALL implement a state machine with states IDLE, GRANT_I and GRANT_D; owner reflects the state.
REQ-012 A port SHALL count as requesting when its CYC and STB are both high.
REQ-013 In IDLE, a single request SHALL move to that port's GRANT state on the next edge, giving one cycle of arbitration latency.
REQ-014 In IDLE with both ports requesting, the grant SHALL go to the port that did not hold the last grant; after reset, DATA wins.
REQ-015 In a GRANT state, ADR, DAT_W, SEL, WE, STB and CYC SHALL route combinationally from the owner to mem_bus.
REQ-016 In IDLE, mem_bus CYC, STB and WE SHALL be 0.
REQ-017 mem_bus DAT_R SHALL be driven to both ports.
REQ-018 mem_bus ACK SHALL be forwarded only to the owner; the non-owner ACK SHALL be 0.
REQ-019 In a GRANT state, if the owner's ACK is high and the other port is requesting, the grant SHALL switch to the other port on the next edge, with no IDLE bubble.
REQ-020 In a GRANT state, if the owner's CYC is low, the state SHALL return to IDLE on the next edge.
REQ-021 Otherwise the grant SHALL hold, giving the owner back-to-back transfers while uncontested.
REQ-022 A timeout counter SHALL count consecutive granted cycles with mem_bus STB high and ACK low.
REQ-023 The timeout counter SHALL reset on ACK, on any grant change and in IDLE.
REQ-024 The timeout counter SHALL saturate and never wrap.
REQ-025 When the timeout counter reaches TIMEOUT, bus_err SHALL set, the state SHALL go to IDLE and last-grant SHALL record the timed-out port.
REQ-026 After a timeout, the timed-out port SHALL NOT be forced into ACK.
REQ-027 An ACK arriving in the same cycle as the timeout SHALL win: it is forwarded and bus_err stays unchanged.
REQ-028 The non-owner SHALL see its CYC/STB ignored; it stalls until granted.

Reset
REQ-029 On rst_n low, SHALL asynchronously enter IDLE, with owner=NONE, bus_err=0, timeout counter=0 and last-grant=INSTR.
REQ-030 Reset asserted mid-transfer SHALL drop mem_bus CYC/STB in the same cycle.
REQ-031 No partial state SHALL survive reset.

Structure
REQ-032 The owner encoding enum and state enum SHALL live in the shared core package alongside the opcode constants.
REQ-033 The block SHALL be a single module with no sub-modules; the timeout counter is inline.
REQ-034 The timeout counter width SHALL be $clog2(TIMEOUT+1).

Verification
REQ-035 The bench SHALL cover: instr-only requests, ACK every cycle -> GRANT_I one cycle after the request, owner stays INSTR, and 8 fetches complete in 9 cycles.
REQ-036 The bench SHALL cover: both ports requesting from reset -> DATA granted first; after its ACK, INSTR is granted on the next edge with no idle cycle.
REQ-037 The bench SHALL cover: instr holding CYC continuously while data requests at cycle 5 -> data is granted on the cycle after the next instr ACK, and instr ACK is 0 until it regains the grant.
REQ-038 The bench SHALL cover: TIMEOUT=4 with the slave never acking -> bus_err rises on the 4th stalled cycle, the state goes to IDLE, and the other pending port is granted next.
REQ-039 The bench SHALL cover: ACK in the same cycle the counter hits TIMEOUT -> ACK is forwarded and bus_err stays 0.
REQ-040 The bench SHALL cover: rst_n pulsed low mid-transfer, asynchronous to clk -> mem_bus CYC=0 immediately, owner=NONE, and bus_err cleared.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared core definitions: arbiter state/owner encodings and memory opcode constants.
// Imported by the Wishbone arbiter and by anything that decodes the owner output.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_INSTR = 2'd1,
    OWNER_DATA  = 2'd2
  } owner_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  function automatic owner_e owner_of(arb_state_e s);
    case (s)
      ST_GRANT_I: return OWNER_INSTR;
      ST_GRANT_D: return OWNER_DATA;
      default:    return OWNER_NONE;
    endcase
  endfunction

  function automatic logic is_mem_opcode(logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE) || (opc == OPC_MISC_MEM);
  endfunction

endpackage

// File: rtl/wishbone.sv
// Classic Wishbone bundle; MASTER drives the request side, SLAVE answers with ACK/DAT_R.
interface wishbone #(
  parameter int XLEN = 32
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic              ack;
  logic [XLEN-1:0]   adr;
  logic [XLEN-1:0]   dat_w;
  logic [XLEN-1:0]   dat_r;
  logic [XLEN/8-1:0] sel;

  modport MASTER (output cyc, stb, we, adr, dat_w, sel, input ack, dat_r);
  modport SLAVE  (input cyc, stb, we, adr, dat_w, sel, output ack, dat_r);
endinterface

// File: rtl/wb_arbiter.sv
// Two-port Wishbone arbiter (instruction fetch vs load/store) onto one memory port,
// alternating under contention, with a saturating ACK-timeout that raises a sticky bus_err.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  wishbone.SLAVE     instr_bus,
  wishbone.SLAVE     data_bus,
  wishbone.MASTER    mem_bus,
  output logic [1:0] owner,
  output logic       bus_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = XLEN / 8;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);

  arb_state_e      state_q, state_d;
  owner_e          owner_q, owner_d;
  owner_e          last_q, last_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;

  logic            grant_i, grant_d;
  logic            instr_req, data_req;
  logic            own_cyc, other_req;
  logic            stall, timeout_hit;

  logic            cyc_mux, stb_mux, we_mux;
  logic [XLEN-1:0] adr_mux, dat_w_mux;
  logic [SW-1:0]   sel_mux;

  // Request routing: only the current owner reaches the memory port; IDLE drives it quiet.
  always_comb begin
    grant_i   = (state_q == ST_GRANT_I);
    grant_d   = (state_q == ST_GRANT_D);
    cyc_mux   = 1'b0;
    stb_mux   = 1'b0;
    we_mux    = 1'b0;
    adr_mux   = '0;
    dat_w_mux = '0;
    sel_mux   = '0;
    if (grant_i) begin
      cyc_mux   = instr_bus.cyc;
      stb_mux   = instr_bus.stb;
      we_mux    = instr_bus.we;
      adr_mux   = instr_bus.adr;
      dat_w_mux = instr_bus.dat_w;
      sel_mux   = instr_bus.sel;
    end else if (grant_d) begin
      cyc_mux   = data_bus.cyc;
      stb_mux   = data_bus.stb;
      we_mux    = data_bus.we;
      adr_mux   = data_bus.adr;
      dat_w_mux = data_bus.dat_w;
      sel_mux   = data_bus.sel;
    end
  end

  assign mem_bus.cyc   = cyc_mux;
  assign mem_bus.stb   = stb_mux;
  assign mem_bus.we    = we_mux;
  assign mem_bus.adr   = adr_mux;
  assign mem_bus.dat_w = dat_w_mux;
  assign mem_bus.sel   = sel_mux;

  assign instr_bus.ack   = grant_i & mem_bus.ack;
  assign data_bus.ack    = grant_d & mem_bus.ack;
  assign instr_bus.dat_r = mem_bus.dat_r;
  assign data_bus.dat_r  = mem_bus.dat_r;

  // An ACK in the would-be timeout cycle is not a stall, so it always beats the timeout.
  always_comb begin
    instr_req   = instr_bus.cyc & instr_bus.stb;
    data_req    = data_bus.cyc & data_bus.stb;
    own_cyc     = grant_i ? instr_bus.cyc : data_bus.cyc;
    other_req   = grant_i ? data_req : instr_req;
    stall       = (grant_i | grant_d) & stb_mux & ~mem_bus.ack;
    cnt_inc     = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + 1'b1;
    timeout_hit = stall & (cnt_inc == CNT_LIMIT);
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    err_d   = err_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (instr_req && data_req) begin
          state_d = (last_q == OWNER_DATA) ? ST_GRANT_I : ST_GRANT_D;
        end else if (instr_req) begin
          state_d = ST_GRANT_I;
        end else if (data_req) begin
          state_d = ST_GRANT_D;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (timeout_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (mem_bus.ack && other_req) begin
          state_d = grant_i ? ST_GRANT_D : ST_GRANT_I;
        end else if (!own_cyc) begin
          state_d = ST_IDLE;
        end
        if (stall && !timeout_hit && (state_d == state_q)) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_GRANT_I) begin
      last_d = OWNER_INSTR;
    end else if (state_d == ST_GRANT_D) begin
      last_d = OWNER_DATA;
    end
    owner_d = owner_of(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_NONE;
      last_q  <= OWNER_INSTR;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign owner   = owner_q;
  assign bus_err = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with TIMEOUT=4 and a combinational memory
// slave whose ACK is gated per cycle by ack_en and whose read data is ADR ^ RD_KEY.
module tb_wb_arbiter;

  localparam int          XLEN    = 32;
  localparam int          TO      = 4;
  localparam logic [1:0]  O_NONE  = 2'd0;
  localparam logic [1:0]  O_INSTR = 2'd1;
  localparam logic [1:0]  O_DATA  = 2'd2;
  localparam logic [31:0] RD_KEY  = 32'hA5A5_0000;

  logic       clk;
  logic       rst_n;
  logic [1:0] owner;
  logic       bus_err;
  logic       ack_en;

  int n_checks;
  int n_fail;

  logic       t_ack  [10];
  logic       t_dreq [10];
  logic [1:0] t_own  [10];
  logic       t_iack [10];
  logic       t_dack [10];
  logic       t_err  [10];

  wishbone #(.XLEN(XLEN)) ib ();
  wishbone #(.XLEN(XLEN)) db ();
  wishbone #(.XLEN(XLEN)) mb ();

  assign mb.ack   = ack_en & mb.cyc & mb.stb;
  assign mb.dat_r = mb.adr ^ RD_KEY;

  wb_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr_bus (ib),
    .data_bus  (db),
    .mem_bus   (mb),
    .owner     (owner),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters;
    ib.cyc = 1'b0; ib.stb = 1'b0; ib.we = 1'b0; ib.adr = '0; ib.dat_w = '0; ib.sel = 4'hF;
    db.cyc = 1'b0; db.stb = 1'b0; db.we = 1'b0; db.adr = '0; db.dat_w = '0; db.sel = 4'hF;
  endtask

  task automatic do_reset;
    rst_n  = 1'b0;
    ack_en = 1'b0;
    idle_masters();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    ack_en = 1'b0;
    idle_masters();
    @(posedge clk);
    #2;
    n_checks++;
    if (owner !== O_NONE) begin
      n_fail++; $display("[TB] FAIL reset_owner: got %0d expected %0d", owner, O_NONE);
    end
    n_checks++;
    if (bus_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_bus_err: got %0b expected 0", bus_err);
    end
    n_checks++;
    if (mb.cyc !== 1'b0 || mb.stb !== 1'b0 || mb.we !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_mem_quiet: got cyc=%0b stb=%0b we=%0b expected 0/0/0",
                         mb.cyc, mb.stb, mb.we);
    end
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (owner !== O_NONE) begin
      n_fail++; $display("[TB] FAIL reset_idle_after_release: got %0d expected %0d", owner, O_NONE);
    end
  endtask

  task automatic test_instr_stream;
    int acks;
    int cycles;
    logic acked;
    logic [31:0] first_dat;
    do_reset();
    ack_en = 1'b1;
    ib.cyc = 1'b1; ib.stb = 1'b1; ib.adr = 32'h0000_0100;
    acks = 0; cycles = 0; first_dat = '0;
    while (acks < 8 && cycles < 20) begin
      #1;
      cycles++;
      acked = (ib.ack === 1'b1);
      if (acked) begin
        acks++;
        if (acks == 1) first_dat = ib.dat_r;
      end
      if (cycles == 1) begin
        n_checks++;
        if (owner !== O_NONE || mb.cyc !== 1'b0) begin
          n_fail++; $display("[TB] FAIL stream_arb_latency: got owner=%0d cyc=%0b expected %0d/0",
                             owner, mb.cyc, O_NONE);
        end
      end else begin
        n_checks++;
        if (owner !== O_INSTR || db.ack !== 1'b0) begin
          n_fail++; $display("[TB] FAIL stream_owner c%0d: got owner=%0d dack=%0b expected %0d/0",
                             cycles, owner, db.ack, O_INSTR);
        end
      end
      tick();
      if (acked) ib.adr = ib.adr + 32'd4;
    end
    n_checks++;
    if (acks != 8 || cycles != 9) begin
      n_fail++; $display("[TB] FAIL stream_throughput: got %0d acks in %0d cycles expected 8 in 9",
                         acks, cycles);
    end
    n_checks++;
    if (first_dat !== 32'hA5A5_0100) begin
      n_fail++; $display("[TB] FAIL stream_dat_r: got %h expected a5a50100", first_dat);
    end
    idle_masters();
    tick();
    n_checks++;
    if (owner !== O_NONE) begin
      n_fail++; $display("[TB] FAIL stream_release_idle: got %0d expected %0d", owner, O_NONE);
    end
  endtask

  task automatic test_both_from_reset;
    do_reset();
    ack_en = 1'b1;
    ib.cyc = 1'b1; ib.stb = 1'b1; ib.adr = 32'h0000_0200;
    db.cyc = 1'b1; db.stb = 1'b1; db.we = 1'b1; db.adr = 32'h0000_0300;
    db.dat_w = 32'hDEAD_BEEF; db.sel = 4'h3;
    #1;
    n_checks++;
    if (owner !== O_NONE || mb.cyc !== 1'b0 || mb.we !== 1'b0) begin
      n_fail++; $display("[TB] FAIL both_idle: got owner=%0d cyc=%0b we=%0b expected 0/0/0",
                         owner, mb.cyc, mb.we);
    end
    tick();
    #1;
    n_checks++;
    if (owner !== O_DATA) begin
      n_fail++; $display("[TB] FAIL both_data_first: got %0d expected %0d", owner, O_DATA);
    end
    n_checks++;
    if (mb.adr !== 32'h0000_0300 || mb.we !== 1'b1 || mb.dat_w !== 32'hDEAD_BEEF || mb.sel !== 4'h3) begin
      n_fail++; $display("[TB] FAIL both_data_route: got adr=%h we=%0b dat=%h sel=%h expected 00000300/1/deadbeef/3",
                         mb.adr, mb.we, mb.dat_w, mb.sel);
    end
    n_checks++;
    if (db.ack !== 1'b1 || ib.ack !== 1'b0 || ib.dat_r !== 32'hA5A5_0300) begin
      n_fail++; $display("[TB] FAIL both_ack_split: got dack=%0b iack=%0b idat=%h expected 1/0/a5a50300",
                         db.ack, ib.ack, ib.dat_r);
    end
    tick();
    db.cyc = 1'b0; db.stb = 1'b0; db.we = 1'b0;
    #1;
    n_checks++;
    if (owner !== O_INSTR || ib.ack !== 1'b1 || mb.adr !== 32'h0000_0200 || mb.we !== 1'b0) begin
      n_fail++; $display("[TB] FAIL both_switch_no_bubble: got owner=%0d iack=%0b adr=%h we=%0b expected %0d/1/00000200/0",
                         owner, ib.ack, mb.adr, mb.we, O_INSTR);
    end
    idle_masters();
    tick();
    tick();
  endtask

  task automatic test_contention;
    do_reset();
    t_ack  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    t_dreq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    t_own  = '{O_NONE, O_INSTR, O_INSTR, O_INSTR, O_INSTR, O_INSTR, O_INSTR, O_INSTR, O_DATA, O_INSTR};
    t_iack = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    t_dack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ib.cyc = 1'b1; ib.stb = 1'b1; ib.adr = 32'h0000_0400;
    db.adr = 32'h0000_0500;
    for (int c = 0; c < 10; c++) begin
      ack_en = t_ack[c];
      db.cyc = t_dreq[c];
      db.stb = t_dreq[c];
      #1;
      n_checks++;
      if (owner !== t_own[c]) begin
        n_fail++; $display("[TB] FAIL contend_owner c%0d: got %0d expected %0d", c, owner, t_own[c]);
      end
      n_checks++;
      if (ib.ack !== t_iack[c] || db.ack !== t_dack[c]) begin
        n_fail++; $display("[TB] FAIL contend_ack c%0d: got iack=%0b dack=%0b expected %0b/%0b",
                           c, ib.ack, db.ack, t_iack[c], t_dack[c]);
      end
      tick();
    end
    idle_masters();
    ack_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout;
    do_reset();
    t_ack  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    t_own  = '{O_NONE, O_DATA, O_DATA, O_DATA, O_DATA, O_NONE, O_INSTR, O_DATA, O_INSTR, O_DATA};
    t_err  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    t_iack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    t_dack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    ib.cyc = 1'b1; ib.stb = 1'b1; ib.adr = 32'h0000_0600;
    db.cyc = 1'b1; db.stb = 1'b1; db.adr = 32'h0000_0700;
    for (int c = 0; c < 10; c++) begin
      ack_en = t_ack[c];
      #1;
      n_checks++;
      if (owner !== t_own[c] || bus_err !== t_err[c]) begin
        n_fail++; $display("[TB] FAIL timeout_state c%0d: got owner=%0d err=%0b expected %0d/%0b",
                           c, owner, bus_err, t_own[c], t_err[c]);
      end
      n_checks++;
      if (ib.ack !== t_iack[c] || db.ack !== t_dack[c]) begin
        n_fail++; $display("[TB] FAIL timeout_ack c%0d: got iack=%0b dack=%0b expected %0b/%0b",
                           c, ib.ack, db.ack, t_iack[c], t_dack[c]);
      end
      tick();
    end
    idle_masters();
    ack_en = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus_err !== 1'b1 || owner !== O_NONE) begin
      n_fail++; $display("[TB] FAIL timeout_sticky: got err=%0b owner=%0d expected 1/%0d",
                         bus_err, owner, O_NONE);
    end
  endtask

  task automatic test_ack_at_timeout;
    do_reset();
    t_ack  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    t_own  = '{O_NONE, O_INSTR, O_INSTR, O_INSTR, O_INSTR, O_INSTR, O_INSTR, O_INSTR, O_INSTR, O_INSTR};
    t_iack = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ib.cyc = 1'b1; ib.stb = 1'b1; ib.adr = 32'h0000_0900;
    for (int c = 0; c < 10; c++) begin
      ack_en = t_ack[c];
      #1;
      n_checks++;
      if (owner !== t_own[c] || bus_err !== 1'b0) begin
        n_fail++; $display("[TB] FAIL ackwin_state c%0d: got owner=%0d err=%0b expected %0d/0",
                           c, owner, bus_err, t_own[c]);
      end
      n_checks++;
      if (ib.ack !== t_iack[c]) begin
        n_fail++; $display("[TB] FAIL ackwin_ack c%0d: got %0b expected %0b", c, ib.ack, t_iack[c]);
      end
      tick();
    end
    idle_masters();
    ack_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_async_reset;
    do_reset();
    ack_en = 1'b0;
    db.cyc = 1'b1; db.stb = 1'b1; db.adr = 32'h0000_0800;
    repeat (8) tick();
    #1;
    n_checks++;
    if (owner !== O_DATA || mb.cyc !== 1'b1 || bus_err !== 1'b1) begin
      n_fail++; $display("[TB] FAIL areset_pre: got owner=%0d cyc=%0b err=%0b expected %0d/1/1",
                         owner, mb.cyc, bus_err, O_DATA);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mb.cyc !== 1'b0 || mb.stb !== 1'b0) begin
      n_fail++; $display("[TB] FAIL areset_mem_drop: got cyc=%0b stb=%0b expected 0/0", mb.cyc, mb.stb);
    end
    n_checks++;
    if (owner !== O_NONE || bus_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL areset_state: got owner=%0d err=%0b expected %0d/0",
                         owner, bus_err, O_NONE);
    end
    tick();
    ib.cyc = 1'b1; ib.stb = 1'b1; ib.adr = 32'h0000_0A00;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (owner !== O_NONE) begin
      n_fail++; $display("[TB] FAIL areset_idle: got %0d expected %0d", owner, O_NONE);
    end
    tick();
    #1;
    n_checks++;
    if (owner !== O_DATA || bus_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL areset_last_grant: got owner=%0d err=%0b expected %0d/0",
                         owner, bus_err, O_DATA);
    end
    idle_masters();
    tick();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    ack_en   = 1'b0;
    idle_masters();
    test_reset();
    test_instr_stream();
    test_both_from_reset();
    test_contention();
    test_timeout();
    test_ack_at_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
